// File: rtl/spi_frame_receiver_if.sv
// Bus bundle for spi_frame_receiver: serial inputs plus the frame valid/ready output side.
// The receiver connects through the slave modport; the stimulus/consumer side uses master.
interface spi_frame_receiver_if #(
    parameter int unsigned WIDTH = 16
);
    logic             cs_n;
    logic             sclk;
    logic             sdi;
    logic [WIDTH-1:0] frame_data;
    logic             frame_valid;
    logic             frame_ready;
    logic             len_err;
    logic             overrun;

    modport master (
        output cs_n, sclk, sdi, frame_ready,
        input  frame_data, frame_valid, len_err, overrun
    );

    modport slave (
        input  cs_n, sclk, sdi, frame_ready,
        output frame_data, frame_valid, len_err, overrun
    );
endinterface

// File: rtl/spi_frame_receiver.sv
// Oversampling 3-wire serial frame deserializer with a valid/ready frame output.
// Optional macro RX_TIMEOUT_EN aborts a frame after TIMEOUT cycles without an sclk rise.
module spi_frame_receiver #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LSB_FIRST   = 1,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                 CLK,
    input  logic                 RST,
    spi_frame_receiver_if.slave  bus
);
    localparam int unsigned CNT_MAX = WIDTH + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    if (SYNC_STAGES < 2 || WIDTH < 2 || TIMEOUT < 2) begin : g_param_check
        $error("spi_frame_receiver: SYNC_STAGES, WIDTH and TIMEOUT must each be at least 2");
    end

    typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_SHIFT} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, sdi_sync_q;
    logic                   cs_dly_q, sclk_dly_q;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   len_err_q, len_err_d;
    logic                   overrun_q, overrun_d;
    logic                   cs_s, sdi_s, cs_rise, cs_fall, sclk_rise;

`ifdef RX_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign cs_rise   = cs_s & ~cs_dly_q;
    assign cs_fall   = ~cs_s & cs_dly_q;
    assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;

    // Synchronizers reset low so ARM only leaves on a genuinely observed cs_n high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cs_sync_q   <= '0;
            sclk_sync_q <= '0;
            sdi_sync_q  <= '0;
            cs_dly_q    <= 1'b0;
            sclk_dly_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
            cs_dly_q    <= cs_s;
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_ARM;
            shift_q   <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            len_err_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef RX_TIMEOUT_EN
            tmr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            len_err_q <= len_err_d;
            overrun_q <= overrun_d;
`ifdef RX_TIMEOUT_EN
            tmr_q     <= tmr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        len_err_d = 1'b0;
        overrun_d = 1'b0;
`ifdef RX_TIMEOUT_EN
        tmr_d     = '0;
`endif
        if (valid_q && bus.frame_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_ARM: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        // Load when empty or when the old frame is consumed this same cycle.
                        if (!valid_q || bus.frame_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        len_err_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    if (cnt_q < CNT_W'(WIDTH)) begin
                        if (LSB_FIRST != 0) begin
                            shift_d = {sdi_s, shift_q[WIDTH-1:1]};
                        end else begin
                            shift_d = {shift_q[WIDTH-2:0], sdi_s};
                        end
                    end
                    if (cnt_q != CNT_W'(CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`ifdef RX_TIMEOUT_EN
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    len_err_d = 1'b1;
                    state_d   = ST_ARM;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
`endif
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    assign bus.frame_data  = data_q;
    assign bus.frame_valid = valid_q;
    assign bus.len_err     = len_err_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed plus randomized bench for spi_frame_receiver against a frame-level reference model.
// Define RX_TIMEOUT_EN to also exercise the sclk stall abort with TIMEOUT = 64.
module tb_spi_frame_receiver;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned LSB   = 1;
`ifdef RX_TIMEOUT_EN
    localparam int unsigned TMO   = 64;
`else
    localparam int unsigned TMO   = 1024;
`endif

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    spi_frame_receiver_if #(.WIDTH(WIDTH)) bus ();

    spi_frame_receiver #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .LSB_FIRST(LSB), .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Observed events, sampled on the falling edge
    int               lerr_seen = 0;
    int               ovr_seen  = 0;
    int               both_seen = 0;
    logic [WIDTH-1:0] got_q[$];

    // Reference model state (transaction level)
    int               exp_lerr = 0;
    int               exp_ovr  = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic             m_valid  = 1'b0;
    logic [WIDTH-1:0] m_data   = '0;
    logic             m_ready  = 1'b0;

    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.len_err) lerr_seen++;
            if (bus.overrun) ovr_seen++;
            if (bus.len_err && bus.overrun) both_seen++;
            if (bus.frame_valid && bus.frame_ready) got_q.push_back(bus.frame_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_frames();
        check("frame_count", 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check("frame_order", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    // Expected word: bit i of the stream weighted by its landing position.
    function automatic logic [WIDTH-1:0] model_word(input logic [63:0] bits);
        logic [WIDTH-1:0] w = '0;
        for (int i = 0; i < int'(WIDTH); i++)
            if (bits[i]) w = w + (WIDTH'(1) << ((LSB != 0) ? i : (int'(WIDTH) - 1 - i)));
        return w;
    endfunction

    task automatic model_frame(input logic [63:0] bits, input int n);
        logic [WIDTH-1:0] w;
        if (n != int'(WIDTH)) begin
            exp_lerr++;
        end else begin
            w = model_word(bits);
            if (m_ready) exp_q.push_back(w);
            else if (m_valid) exp_ovr++;
            else begin
                m_valid = 1'b1;
                m_data  = w;
            end
        end
    endtask

    task automatic set_ready(input logic r);
        bus.frame_ready = r;
        m_ready = r;
        if (r && m_valid) begin
            exp_q.push_back(m_data);
            m_valid = 1'b0;
        end
    endtask

    task automatic open_frame();
        bus.cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic shift_bits(input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.sdi = bits[i];
            wait_clk(3);
            bus.sclk = 1'b1;
            wait_clk(3);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic close_frame();
        wait_clk(3);
        bus.cs_n = 1'b1;
    endtask

    task automatic full_frame(input logic [63:0] bits, input int n);
        open_frame();
        shift_bits(bits, n);
        close_frame();
        wait_clk(8);
        model_frame(bits, n);
    endtask

    initial begin
        logic [63:0] bits;
        int          n;
        int          lerr_ref;

        RST = 1'b1;
        bus.cs_n = 1'b1;
        bus.sclk = 1'b0;
        bus.sdi = 1'b0;
        bus.frame_ready = 1'b0;
        wait_clk(3);
        check("rst_frame_data", 32'(bus.frame_data), 32'h0);
        check("rst_frame_valid", 32'(bus.frame_valid), 32'h0);
        check("rst_len_err", 32'(bus.len_err), 32'h0);
        check("rst_overrun", 32'(bus.overrun), 32'h0);
        RST = 1'b0;
        wait_clk(6);

        // Single frame and cs_n-rise-to-valid latency
        bits = 64'hE000;
        open_frame();
        shift_bits(bits, 16);
        close_frame();
        wait_clk(SYNC);
        check("latency_before", 32'(bus.frame_valid), 32'h0);
        wait_clk(1);
        check("latency_at", 32'(bus.frame_valid), 32'h1);
        wait_clk(5);
        model_frame(bits, 16);
        check("t1_data", 32'(bus.frame_data), 32'(m_data));
        check("t1_len_err", 32'(lerr_seen), 32'(exp_lerr));

        // Wrong lengths: zero, short, long
        set_ready(1'b1);
        wait_clk(3);
        check_frames();
        full_frame(64'h0, 0);
        full_frame(64'h5A5A, 15);
        full_frame(64'h1_A5A5, 17);
        check("t2_len_err", 32'(lerr_seen), 32'(exp_lerr));
        check("t2_valid", 32'(bus.frame_valid), 32'h0);

        // Overrun while the output is held full
        set_ready(1'b0);
        full_frame(64'h3800, 16);
        full_frame(64'h0E00, 16);
        check("t3_data", 32'(bus.frame_data), 32'(m_data));
        check("t3_overrun", 32'(ovr_seen), 32'(exp_ovr));
        set_ready(1'b1);
        check("t3_valid_held", 32'(bus.frame_valid), 32'h1);
        wait_clk(1);
        check("t3_valid_drop", 32'(bus.frame_valid), 32'h0);
        check_frames();

        // Accept of the old frame coincides with load of the new one
        set_ready(1'b0);
        full_frame(64'h1110, 16);
        open_frame();
        shift_bits(64'h3B90, 16);
        close_frame();
        wait_clk(SYNC);
        bus.frame_ready = 1'b1;
        m_ready = 1'b1;
        exp_q.push_back(m_data);
        m_valid = 1'b0;
        exp_q.push_back(model_word(64'h3B90));
        wait_clk(1);
        check("t4_valid_kept", 32'(bus.frame_valid), 32'h1);
        check("t4_new_data", 32'(bus.frame_data), 32'h3B90);
        wait_clk(1);
        check("t4_valid_drop", 32'(bus.frame_valid), 32'h0);
        check("t4_overrun", 32'(ovr_seen), 32'(exp_ovr));
        check_frames();

        // Reset in the middle of a frame must not produce anything on completion
        open_frame();
        shift_bits(64'hA5, 8);
        RST = 1'b1;
        wait_clk(2);
        m_valid = 1'b0;
        RST = 1'b0;
        wait_clk(2);
        check("t5_valid_after_rst", 32'(bus.frame_valid), 32'h0);
        shift_bits(64'h3C, 8);
        close_frame();
        wait_clk(8);
        check("t5_no_len_err", 32'(lerr_seen), 32'(exp_lerr));
        check("t5_no_frame", 32'(got_q.size()), 32'h0);
        full_frame(64'hCCC0, 16);
        check_frames();

`ifdef RX_TIMEOUT_EN
        // sclk stall aborts the frame; the closing cs_n rise is then ignored
        open_frame();
        shift_bits(64'h15, 5);
        wait_clk(TMO + 10);
        exp_lerr++;
        check("t6_timeout_len_err", 32'(lerr_seen), 32'(exp_lerr));
        close_frame();
        wait_clk(8);
        check("t6_close_ignored", 32'(lerr_seen), 32'(exp_lerr));
        set_ready(1'b0);
        full_frame(64'hFFF0, 16);
        check("t6_valid", 32'(bus.frame_valid), 32'h1);
        check("t6_data", 32'(bus.frame_data), 32'hFFF0);
        set_ready(1'b1);
        wait_clk(2);
        check_frames();
`endif

        // Randomized frames and back-pressure
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                set_ready(~m_ready);
                wait_clk(2);
            end
            bits = {$urandom, $urandom};
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(WIDTH - 3, WIDTH + 3)) : int'(WIDTH);
            full_frame(bits, n);
        end
        set_ready(1'b1);
        wait_clk(4);
        lerr_ref = exp_lerr;
        check("rnd_len_err", 32'(lerr_seen), 32'(lerr_ref));
        check("rnd_overrun", 32'(ovr_seen), 32'(exp_ovr));
        check("rnd_exclusive", 32'(both_seen), 32'h0);
        check("rnd_valid_idle", 32'(bus.frame_valid), 32'h0);
        check_frames();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
